alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Upstream-facing driver for the 4-bit combinational ALU.
- Accepts operation commands over a valid/ready interface and registers them onto the ALU operand/control inputs.
- Captures the ALU result/carry/zero one cycle later and returns them through a buffered valid/ready response interface.
- Sits between a command source (sequencer/testbench agent) and the ALU; owns all timing, so the ALU stays purely combinational.

Parameters:
- DATA_W, 4, operand/result width; must equal ALU width.
- RESP_DEPTH, 4, response FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept command.
- cmd_op  in  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 PASS.
- cmd_a  in  DATA_W  operand a.
- cmd_b  in  DATA_W  operand b.
- cmd_use_acc  in  1  substitute accumulator for a; only honoured with ALU_CHAIN_EN.
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_ctrl  out  3  to ALU alu_ctrl.
- alu_result  in  DATA_W  from ALU result.
- alu_carry_out  in  1  from ALU carry_out.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response available (FIFO non-empty).
- rsp_ready  in  1  consumer takes response.
- rsp_op  out  3  op code of the head response.
- rsp_result  out  DATA_W  result.
- rsp_carry  out  1  carry flag.
- rsp_zero  out  1  zero flag.

Behaviour:
- Reset (async assert, sync release):
  - alu_a, alu_b, alu_ctrl = 0.
  - Stage-1 valid (s1_vld) = 0.
  - FIFO empty, so rsp_valid = 0; rsp_* data = 0.
  - Accumulator = 0.
  - cmd_ready = 1 from the first cycle after rst_n deasserts.
- Pipeline, two stages:
  - Cycle N, accept: cmd_valid && cmd_ready. alu_a/alu_b/alu_ctrl and stage-1 op register load at edge N; s1_vld is set.
  - Cycle N+1, capture: while s1_vld, the ALU outputs are settled and are written into the FIFO at edge N+1.
  - rsp_valid rises in cycle N+2. Accept-to-rsp_valid latency = 2 cycles.
  - Throughput is 1 command/cycle when credit is available.
- Carry rule:
  - For ops 000/001, rsp_carry = alu_carry_out.
  - For all other ops, rsp_carry is forced to 0 (ALU carry undefined there).
  - rsp_zero = alu_zero unmodified.
- Credit:
  - cmd_ready = (fifo_count + s1_vld) < RESP_DEPTH. Combinational from registered state; never depends on cmd_valid.
  - A FIFO pop in the same cycle does not raise cmd_ready that cycle (no pop-to-ready path).
- ALU outputs hold their last value when no command is accepted. No bubble zeroing.
- FIFO:
  - Push and pop are independent. Simultaneous push+pop leaves the count unchanged.
  - Pointers wrap modulo RESP_DEPTH.
  - Overflow cannot occur by construction. A push when full is an assertion failure.
  - rsp_* data is stable while rsp_valid && !rsp_ready.
- FSM per command slot: EMPTY -> DRIVE (accepted) -> CAPTURED (in FIFO) -> retired on pop.
  - DRIVE lasts exactly 1 cycle.
  - An accept in the same cycle as a capture keeps s1_vld = 1.
- Reset mid-operation: in-flight command and all FIFO contents are discarded; no response is emitted for them.

Optional Feature:
- Macro: ALU_CHAIN_EN.
- Defined:
  - The accumulator register loads alu_result on every capture.
  - On accept with cmd_use_acc = 1, alu_a is taken from the accumulator instead of cmd_a.
  - If the previous command is still in DRIVE (s1_vld = 1) at that accept, alu_a is forwarded from alu_result of that command. Back-to-back chains therefore work with no stall.
- Undefined:
  - cmd_use_acc is ignored; alu_a always equals cmd_a.
  - No accumulator register exists.

Test Plan:
- After reset, ADD a=9 b=8, rsp_ready=1 -> rsp_valid in cycle 2 after accept; result=0x1, carry=1, zero=0, op=000.
- SUB a=3 b=5 -> result=0xE, carry=1. Then AND a=5 b=A -> result=0x0, zero=1, carry=0 (forced).
- rsp_ready=0, drive cmd_valid continuously with ops XOR/OR/SHL/SHR/PASS -> exactly 4 accepts, then cmd_ready=0. Raise rsp_ready -> responses pop in order with correct values; cmd_ready returns one cycle after the first pop.
- Simultaneous push+pop at FIFO count=2 for 6 cycles -> count stays 2; pointers wrap past 3 with correct data order.
- ALU_CHAIN_EN: ADD 7+1, next cycle ADD use_acc=1 b=2, next cycle SHL use_acc=1 -> results 0x8, 0xA, 0x4. Without the macro, the same stimulus with cmd_a=0 gives 0x8, 0x2, 0x0.
- Assert rst_n low with 1 command in DRIVE and 3 in the FIFO -> rsp_valid=0 and ALU outputs=0 immediately. After release cmd_ready=1 and no stale response appears.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Purpose : registers valid/ready ALU commands onto a combinational ALU and
//           returns the captured result/carry/zero through a response FIFO.
// Latency : 2 cycles from accept to rsp_valid; 1 command/cycle sustained.
// Backpressure: credit based. cmd_ready drops once the FIFO entries plus the
//           in-flight command reach RESP_DEPTH. A pop does not raise cmd_ready
//           in the same cycle.
//
// Optional macro: ALU_CHAIN_EN adds an accumulator. It loads on every capture.
//   With cmd_use_acc=1, alu_a comes from the accumulator, or from the live ALU
//   result when the previous command is still in the drive stage.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/cmd_a/cmd_b            command fields
//   cmd_use_acc                   chain operand select (ALU_CHAIN_EN only)
//   alu_a/alu_b/alu_ctrl          registered ALU inputs
//   alu_result/carry_out/zero     ALU outputs, captured one cycle after accept
//   rsp_valid/rsp_ready           response handshake (FIFO head)
//   rsp_op/rsp_result/rsp_carry/rsp_zero   response fields

// Purpose : generic synchronous FIFO with occupancy count.
// Latency : write visible at head the cycle after push.
// Backpressure: none internally; the caller must never push when full.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && (count == CW'(DEPTH))));
endmodule

module alu_cmd_driver #(
  parameter int DATA_W     = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
  } rsp_t;

  typedef enum logic {S1_EMPTY = 1'b0, S1_DRIVE = 1'b1} s1_state_t;

  s1_state_t         s1_state;
  logic              s1_vld;
  logic              accept;
  logic              capture;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] next_a;
  rsp_t              push_dat;
  rsp_t              head_dat;

  assign s1_vld  = (s1_state == S1_DRIVE);
  assign accept  = cmd_valid && cmd_ready;
  assign capture = s1_vld;

  // The in-flight command already holds a FIFO slot, so the credit check
  // counts it. Only registered state is used, so there is no pop-to-ready path.
  assign cmd_ready = (fifo_count + CW'(s1_vld)) < CW'(RESP_DEPTH);

`ifdef ALU_CHAIN_EN
  logic [DATA_W-1:0] acc;

  // The previous result is not in acc yet while that command is in DRIVE,
  // so forward the live ALU output instead.
  always_comb begin
    next_a = cmd_a;
    if (cmd_use_acc) next_a = s1_vld ? alu_result : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (capture) acc <= alu_result;
  end
`else
  logic unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
  assign next_a         = cmd_a;
`endif

  // Drive stage: ALU inputs hold between commands. alu_ctrl also serves as the
  // op register of the command in DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state <= S1_EMPTY;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else begin
      if (accept) begin
        alu_a    <= next_a;
        alu_b    <= cmd_b;
        alu_ctrl <= cmd_op;
      end
      case (s1_state)
        S1_EMPTY: if (accept)  s1_state <= S1_DRIVE;
        S1_DRIVE: if (!accept) s1_state <= S1_EMPTY;
        default:               s1_state <= S1_EMPTY;
      endcase
    end
  end

  // The ALU carry is only meaningful for ADD and SUB.
  always_comb begin
    push_dat.op     = alu_ctrl;
    push_dat.result = alu_result;
    push_dat.carry  = ((alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB)) ? alu_carry_out : 1'b0;
    push_dat.zero   = alu_zero;
  end

  alu_cmd_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (capture),
    .push_dat (push_dat),
    .pop      (rsp_ready),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign rsp_valid  = (fifo_count != '0);
  assign rsp_op     = head_dat.op;
  assign rsp_result = head_dat.result;
  assign rsp_carry  = head_dat.carry;
  assign rsp_zero   = head_dat.zero;
endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_result;
  logic       alu_carry_out;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_op;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.DATA_W(4), .RESP_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_use_acc   (cmd_use_acc),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .alu_zero      (alu_zero),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
    .rsp_zero      (rsp_zero)
  );

  // Combinational 4-bit ALU. SUB carry is the borrow (a < b). Other ops
  // drive carry high, so the driver's carry masking is visible.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum       = '0;
    alu_result    = '0;
    alu_carry_out = 1'b1;
    case (alu_ctrl)
      3'd0: begin
        alu_sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result    = alu_sum[3:0];
        alu_carry_out = alu_sum[4];
      end
      3'd1: begin
        alu_result    = alu_a - alu_b;
        alu_carry_out = (alu_a < alu_b);
      end
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = alu_a << 1;
      3'd6:    alu_result = alu_a >> 1;
      default: alu_result = alu_a;
    endcase
  end
  assign alu_zero = (alu_result == 4'd0);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic use_acc);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
  endtask

  logic [2:0] t3_op  [5];
  logic [3:0] t3_a   [5];
  logic [3:0] t3_b   [5];
  logic [3:0] t3_exp [4];
  int         n_acc;
  logic [3:0] e_fwd1, e_fwd2, e_r2, e_r3;

  initial begin
    t3_op  = '{3'd4, 3'd3, 3'd5, 3'd6, 3'd7};
    t3_a   = '{4'hC, 4'h5, 4'h9, 4'h9, 4'h1};
    t3_b   = '{4'hA, 4'h2, 4'h0, 4'h0, 4'h0};
    t3_exp = '{4'h6, 4'h7, 4'h2, 4'h4};
`ifdef ALU_CHAIN_EN
    e_fwd1 = 4'h8; e_fwd2 = 4'hA; e_r2 = 4'hA; e_r3 = 4'h4;
`else
    e_fwd1 = 4'h0; e_fwd2 = 4'h0; e_r2 = 4'h2; e_r3 = 4'h0;
`endif

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_rsp_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);

    // ADD 9+8: result 1, carry 1, two-cycle latency.
    drive(3'd0, 4'h9, 4'h8, 1'b0);
    chk("add_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("add_alu_a", alu_a, 4'h9);
    chk("add_alu_b", alu_b, 4'h8);
    chk("add_alu_ctrl", alu_ctrl, 3'd0);
    chk("add_rsp_valid_n1", rsp_valid, 0);
    tick();
    chk("add_rsp_valid_n2", rsp_valid, 1);
    chk("add_result", rsp_result, 4'h1);
    chk("add_carry", rsp_carry, 1);
    chk("add_zero", rsp_zero, 0);
    chk("add_op", rsp_op, 3'd0);
    rsp_ready = 1'b1;
    tick();
    chk("add_popped", rsp_valid, 0);

    // SUB 3-5 then AND 5&A back to back.
    drive(3'd1, 4'h3, 4'h5, 1'b0);
    tick();
    drive(3'd2, 4'h5, 4'hA, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("sub_valid", rsp_valid, 1);
    chk("sub_result", rsp_result, 4'hE);
    chk("sub_carry", rsp_carry, 1);
    chk("sub_op", rsp_op, 3'd1);
    tick();
    chk("and_valid", rsp_valid, 1);
    chk("and_result", rsp_result, 4'h0);
    chk("and_zero", rsp_zero, 1);
    chk("and_carry_forced", rsp_carry, 0);
    chk("and_op", rsp_op, 3'd2);
    tick();
    chk("and_popped", rsp_valid, 0);

    // Fill with rsp_ready low: exactly four accepts, then credit exhausted.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(t3_op[(n_acc < 5) ? n_acc : 4], t3_a[(n_acc < 5) ? n_acc : 4],
            t3_b[(n_acc < 5) ? n_acc : 4], 1'b0);
      if (cmd_ready) n_acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("fill_accepts", 8'(n_acc), 4);
    chk("fill_ready_low", cmd_ready, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) chk("drain_ready_same_cycle", cmd_ready, 0);
      if (k == 1) chk("drain_ready_next_cycle", cmd_ready, 1);
      chk("drain_valid", rsp_valid, 1);
      chk("drain_result", rsp_result, t3_exp[k]);
      chk("drain_op", rsp_op, t3_op[k]);
      chk("drain_carry_forced", rsp_carry, 0);
      tick();
    end
    chk("drain_empty", rsp_valid, 0);

    // Steady push+pop at count 2; pointers wrap, order preserved.
    for (int i = 0; i < 9; i++) begin
      drive(3'd7, 4'(i + 1), 4'h0, 1'b0);
      rsp_ready = (i >= 3);
      if (i >= 3) begin
        chk("stream_valid", rsp_valid, 1);
        chk("stream_result", rsp_result, 8'(i - 2));
        chk("stream_ready", cmd_ready, 1);
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int j = 7; j <= 9; j++) begin
      chk("stream_tail_valid", rsp_valid, 1);
      chk("stream_tail_result", rsp_result, 8'(j));
      tick();
    end
    chk("stream_empty", rsp_valid, 0);

    // Accumulator chain: ADD 7+1, ADD acc+2, SHL acc.
    drive(3'd0, 4'h7, 4'h1, 1'b0);
    tick();
    drive(3'd0, 4'h0, 4'h2, 1'b1);
    tick();
    drive(3'd5, 4'h0, 4'h0, 1'b1);
    chk("chain_r1", rsp_result, 4'h8);
    chk("chain_fwd_a1", alu_a, e_fwd1);
    tick();
    cmd_valid = 1'b0;
    cmd_use_acc = 1'b0;
    chk("chain_r2", rsp_result, e_r2);
    chk("chain_fwd_a2", alu_a, e_fwd2);
    tick();
    chk("chain_r3", rsp_result, e_r3);
    chk("chain_r3_valid", rsp_valid, 1);
    tick();
    chk("chain_empty", rsp_valid, 0);

    // Reset with one command in DRIVE and three in the FIFO.
    rsp_ready = 1'b0;
    drive(3'd7, 4'h1, 4'h0, 1'b0); tick();
    drive(3'd7, 4'h2, 4'h0, 1'b0); tick();
    drive(3'd7, 4'h3, 4'h0, 1'b0); tick();
    drive(3'd4, 4'h5, 4'h3, 1'b0); tick();
    cmd_valid = 1'b0;
    chk("mid_ready_full", cmd_ready, 0);
    chk("mid_valid", rsp_valid, 1);
    chk("mid_alu_ctrl", alu_ctrl, 3'd4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_ctrl", alu_ctrl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("after_rst_ready", cmd_ready, 1);
    chk("after_rst_valid", rsp_valid, 0);
    rsp_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("no_stale_rsp", rsp_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
